// File: rtl/online_sd_converter.sv
// On-the-fly conversion of a radix-2 signed-digit stream (MSD first) into an
// N+1 bit two's-complement word, with no final carry-propagate add.
module online_sd_converter #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         in_valid,
  input  logic         d_plus,
  input  logic         d_minus,
  output logic         busy,
  output logic         out_valid,
  output logic [N:0]   result
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [0:0] {IDLE, CONVERT} state_t;

  state_t          state_q, state_d;
  logic [N:0]      q_q, q_d;
  logic [N:0]      qm_q, qm_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [N:0]      result_q, result_d;
  logic            out_valid_q, out_valid_d;
  logic            dpos, dneg;

  assign dpos = d_plus & ~d_minus;
  assign dneg = ~d_plus & d_minus;

  always_comb begin
    state_d     = state_q;
    q_d         = q_q;
    qm_d        = qm_q;
    cnt_d       = cnt_q;
    result_d    = result_q;
    out_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = CONVERT;
          q_d     = '0;
          qm_d    = '1;
          cnt_d   = '0;
        end
      end
      CONVERT: begin
        if (in_valid) begin
          // Q and QM = Q-1 are both kept so a -1 digit never needs a borrow.
          if (dpos) begin
            q_d  = {q_q[N-1:0], 1'b1};
            qm_d = {q_q[N-1:0], 1'b0};
          end else if (dneg) begin
            q_d  = {qm_q[N-1:0], 1'b1};
            qm_d = {qm_q[N-1:0], 1'b0};
          end else begin
            q_d  = {q_q[N-1:0], 1'b0};
            qm_d = {qm_q[N-1:0], 1'b1};
          end
          if (cnt_q == LAST) begin
            result_d    = q_d;
            out_valid_d = 1'b1;
            state_d     = IDLE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      q_q         <= '0;
      qm_q        <= '1;
      cnt_q       <= '0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      q_q         <= q_d;
      qm_q        <= qm_d;
      cnt_q       <= cnt_d;
      result_q    <= result_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign busy      = (state_q == CONVERT);
  assign out_valid = out_valid_q;
  assign result    = result_q;

endmodule
